detector_jogada: RTL and testbench
==================================

// Module: detector_jogada
// PURPOSE
//   Player-side producer of the jogada/botoes interface consumed by the game control unit.
//   Synchronises and debounces the raw push-buttons and accepts one press at a time.
//   For each valid single-button press it emits a 1-cycle jogada pulse.
//   It holds the one-hot button code on botao_reg for the registraR capture.
//   Sits between the board buttons and the datapath/control unit.
// PARAMETERS
//   N_BOTOES         4      number of buttons (width of botoes/botao_reg)
//   DEBOUNCE_CICLOS  50000  stable cycles required for press and release (1 ms @ 50 MHz); >=1
//   W_CONT           16     debounce counter width; must satisfy 2**W_CONT > DEBOUNCE_CICLOS
// PORTS
//   clock        in   1         system clock, rising edge
//   reset        in   1         asynchronous, active-low (0 = reset)
//   botoes       in   N_BOTOES  raw buttons, active-high, asynchronous to clock
//   habilita     in   1         1 = presses may generate jogada; 0 = presses consumed silently
//   jogada       out  1         1-cycle pulse per accepted press
//   botao_reg    out  N_BOTOES  one-hot code of last accepted press, held until next accepted press
//   db_multiplo  out  1         1 while the press being held was rejected as multi-button
//   db_estado    out  3         current FSM state code
// BEHAVIOUR
//   Reset (reset=0, any time, async): state OCIOSO, cont=0, padrao=0, sync FFs=0.
//     Outputs after reset: jogada=0, botao_reg=0, db_multiplo=0, db_estado=0.
//   Sync: 2-FF synchroniser per bit; FSM sees sinc = botoes delayed 2 edges.
//   States (db_estado): OCIOSO=0, FILTRA_PRESS=1, PULSO=2, SEGURA=3, FILTRA_SOLTA=4.
//     Codes 5-7 are unused; any of them -> OCIOSO.
//   OCIOSO:
//     sinc!=0 -> FILTRA_PRESS; padrao<=sinc, cont<=0.
//   FILTRA_PRESS:
//     sinc==0 -> OCIOSO (glitch).
//     sinc!=padrao (nonzero) -> stay; padrao<=sinc, cont<=0 (restart).
//     sinc==padrao, cont==DEBOUNCE_CICLOS-1:
//       padrao one-hot and habilita=1 -> PULSO; botao_reg<=padrao.
//       padrao not one-hot -> SEGURA; db_multiplo<=1.
//       habilita=0 -> SEGURA, no pulse, botao_reg unchanged.
//     else cont<=cont+1.
//   PULSO: jogada=1 for exactly this cycle (Moore); -> SEGURA unconditionally.
//   SEGURA:
//     sinc==0 -> FILTRA_SOLTA, cont<=0.
//     else stay; added buttons ignored.
//   FILTRA_SOLTA:
//     sinc!=0 -> SEGURA (release bounce).
//     sinc==0 and cont==DEBOUNCE_CICLOS-1 -> OCIOSO; db_multiplo<=0.
//     else cont<=cont+1.
//   Latency: raw press first sampled at edge k, stable thereafter -> jogada high in the cycle after edge k+DEBOUNCE_CICLOS+2.
//   At most one jogada per press; a new press is recognised only after a debounced full release.
//   habilita is sampled only at the decision edge of FILTRA_PRESS; changes elsewhere have no effect.
//   botao_reg is stable from the PULSO cycle until the next PULSO, so a capture 1 cycle after jogada is valid.
//   Reset mid-press: on reset release the FSM restarts in OCIOSO.
//     A button still held is treated as a new press and produces jogada after full debounce.
// STRUCTURE
//   Shared package: state codes (OCIOSO..FILTRA_SOLTA), default DEBOUNCE_CICLOS, N_BOTOES.
//   N_BOTOES is shared with the control unit/datapath.
//   One sub-module: sincronizador (N-bit 2-FF synchroniser, async active-low reset). FSM and counter stay inline.
// TESTING (DEBOUNCE_CICLOS=4, N_BOTOES=4)
//   1 Clean press 0010, first sampled edge 10, habilita=1:
//     jogada=1 only between edges 16-17; botao_reg=0010 from edge 16; db_estado 0->1->2->3.
//   2 Bounce 0010/0000 alternating 3 cycles, then stable:
//     exactly one jogada, timed from the last transition to stable.
//   3 Press 0110:
//     no jogada; db_multiplo=1 until debounced release; botao_reg keeps previous value.
//   4 Press held 20 cycles, release bounce 0000/1000, then release:
//     single jogada; FSM SEGURA<->FILTRA_SOLTA; OCIOSO 4 cycles after stable release.
//   5 habilita=0 during press 0001:
//     no jogada; raising habilita while still held gives no jogada until release and re-press.
//   6 reset=0 asserted in FILTRA_PRESS with button held, released after 3 cycles:
//     outputs 0 immediately (async); jogada 7 edges after reset deassertion.

Source files
------------

// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the player-side press detector and its consumers.
package detector_jogada_pkg;

  // Button count shared with the control unit and datapath.
  localparam int N_BOTOES_PADRAO = 4;

  // 1 ms of stability at 50 MHz.
  localparam int DEBOUNCE_PADRAO = 50000;

  // FSM state codes, also exported on db_estado.
  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    FILTRA_PRESS = 3'd1,
    PULSO        = 3'd2,
    SEGURA       = 3'd3,
    FILTRA_SOLTA = 3'd4
  } estado_t;

endpackage

// File: rtl/detector_jogada_sincronizador.sv
// N-bit two-flop synchroniser for the raw, asynchronous push-buttons.
module detector_jogada_sincronizador #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] entrada,
  output logic [LARGURA-1:0] saida
);

  logic [LARGURA-1:0] meta_p0;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_p0 <= '0;
      saida   <= '0;
    end else begin
      meta_p0 <= entrada;
      saida   <= meta_p0;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Debounces the push-buttons and turns each valid single-button press into
// a one-cycle jogada pulse, holding the one-hot code on botao_reg.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
  parameter int W_CONT          = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  output logic                jogada,
  output logic [N_BOTOES-1:0] botao_reg,
  output logic                db_multiplo,
  output logic [2:0]          db_estado
);

  localparam logic [W_CONT-1:0] CONT_FIM = W_CONT'(DEBOUNCE_CICLOS - 1);

  estado_t             estado, estado_n;
  logic [W_CONT-1:0]   cont, cont_n;
  logic [N_BOTOES-1:0] padrao, padrao_n;
  logic [N_BOTOES-1:0] botao_reg_n;
  logic                multiplo_n;
  logic [N_BOTOES-1:0] sinc;

  // True when exactly one button is down.
  function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < N_BOTOES; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

  detector_jogada_sincronizador #(
    .LARGURA (N_BOTOES)
  ) u_sincronizador (
    .clock   (clock),
    .reset   (reset),
    .entrada (botoes),
    .saida   (sinc)
  );

  // State, debounce counter, captured pattern and held outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      cont        <= '0;
      padrao      <= '0;
      botao_reg   <= '0;
      db_multiplo <= 1'b0;
    end else begin
      estado      <= estado_n;
      cont        <= cont_n;
      padrao      <= padrao_n;
      botao_reg   <= botao_reg_n;
      db_multiplo <= multiplo_n;
    end
  end

  // Next-state logic: filter the press, decide once, then filter the release.
  always_comb begin
    estado_n    = estado;
    cont_n      = cont;
    padrao_n    = padrao;
    botao_reg_n = botao_reg;
    multiplo_n  = db_multiplo;
    case (estado)
      OCIOSO: begin
        if (sinc != '0) begin
          estado_n = FILTRA_PRESS;
          padrao_n = sinc;
          cont_n   = '0;
        end
      end
      FILTRA_PRESS: begin
        if (sinc == '0) begin
          estado_n = OCIOSO;
        end else if (sinc != padrao) begin
          // Pattern still changing: restart the stability window.
          padrao_n = sinc;
          cont_n   = '0;
        end else if (cont == CONT_FIM) begin
          // habilita only matters here, at the decision point.
          if (!eh_one_hot(padrao)) begin
            estado_n   = SEGURA;
            multiplo_n = 1'b1;
          end else if (habilita) begin
            estado_n    = PULSO;
            botao_reg_n = padrao;
          end else begin
            estado_n = SEGURA;
          end
        end else begin
          cont_n = cont + W_CONT'(1);
        end
      end
      PULSO: begin
        estado_n = SEGURA;
      end
      SEGURA: begin
        // Extra buttons pressed while holding are ignored.
        if (sinc == '0) begin
          estado_n = FILTRA_SOLTA;
          cont_n   = '0;
        end
      end
      FILTRA_SOLTA: begin
        if (sinc != '0) begin
          estado_n = SEGURA;
        end else if (cont == CONT_FIM) begin
          estado_n   = OCIOSO;
          multiplo_n = 1'b0;
        end else begin
          cont_n = cont + W_CONT'(1);
        end
      end
      default: begin
        estado_n = OCIOSO;
      end
    endcase
  end

  assign jogada    = (estado == PULSO);
  assign db_estado = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with a scoreboard of expected presses.
module tb_detector_jogada;

  localparam int NB = 4;
  localparam int DB = 4;

  logic          clock;
  logic          reset;
  logic [NB-1:0] botoes;
  logic          habilita;
  logic          jogada;
  logic [NB-1:0] botao_reg;
  logic          db_multiplo;
  logic [2:0]    db_estado;

  int compared   = 0;
  int mismatched = 0;

  // Button codes expected on botao_reg at each future jogada pulse.
  logic [NB-1:0] esperados[$];

  detector_jogada #(
    .N_BOTOES        (NB),
    .DEBOUNCE_CICLOS (DB),
    .W_CONT          (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .botoes      (botoes),
    .habilita    (habilita),
    .jogada      (jogada),
    .botao_reg   (botao_reg),
    .db_multiplo (db_multiplo),
    .db_estado   (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic confere(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  // Full debounced release from SEGURA; multiplo flag must survive until the end.
  task automatic soltar(input string tag, input logic mult);
    botoes = '0;
    repeat (6) ciclo();
    confere({tag, "_solta_estado"}, 8'(db_estado), 8'd4);
    confere({tag, "_solta_mult"}, 8'(db_multiplo), 8'(mult));
    ciclo();
    confere({tag, "_ocioso"}, 8'(db_estado), 8'd0);
    confere({tag, "_mult_limpo"}, 8'(db_multiplo), 8'd0);
  endtask

  // Every jogada pulse consumes one scoreboard entry.
  always @(negedge clock) begin
    if (reset === 1'b1 && jogada === 1'b1) begin
      compared++;
      assert (esperados.size() != 0) else begin
        mismatched++;
        $error("FAIL jogada_inesperada: observed pulse botao_reg=%b expected none", botao_reg);
      end
      if (esperados.size() != 0) begin
        logic [NB-1:0] e;
        e = esperados.pop_front();
        compared++;
        assert (botao_reg === e) else begin
          mismatched++;
          $error("FAIL botao_no_pulso: observed %b expected %b", botao_reg, e);
        end
      end
    end
  end

  initial begin
    reset    = 1'b0;
    botoes   = '0;
    habilita = 1'b1;
    repeat (2) ciclo();
    confere("rst_jogada", 8'(jogada), 8'd0);
    confere("rst_botao", 8'(botao_reg), 8'd0);
    confere("rst_mult", 8'(db_multiplo), 8'd0);
    confere("rst_estado", 8'(db_estado), 8'd0);
    reset = 1'b1;
    repeat (2) ciclo();
    confere("idle_estado", 8'(db_estado), 8'd0);

    // 1: clean press
    esperados.push_back(4'b0010);
    botoes = 4'b0010;
    repeat (2) ciclo();
    confere("t1_ainda_ocioso", 8'(db_estado), 8'd0);
    ciclo();
    confere("t1_filtra", 8'(db_estado), 8'd1);
    repeat (3) ciclo();
    confere("t1_pre_pulso", 8'(jogada), 8'd0);
    ciclo();
    confere("t1_pulso_estado", 8'(db_estado), 8'd2);
    confere("t1_jogada", 8'(jogada), 8'd1);
    confere("t1_botao", 8'(botao_reg), 8'h2);
    ciclo();
    confere("t1_segura", 8'(db_estado), 8'd3);
    confere("t1_jogada_fim", 8'(jogada), 8'd0);
    confere("t1_botao_mantido", 8'(botao_reg), 8'h2);
    soltar("t1", 1'b0);

    // 2: press bounce, then stable
    esperados.push_back(4'b0010);
    botoes = 4'b0010; ciclo();
    botoes = 4'b0000; ciclo();
    botoes = 4'b0010;
    repeat (6) ciclo();
    confere("t2_sem_pulso_cedo", 8'(jogada), 8'd0);
    ciclo();
    confere("t2_pulso", 8'(db_estado), 8'd2);
    ciclo();
    soltar("t2", 1'b0);

    // 3: two buttons at once
    botoes = 4'b0110;
    repeat (7) ciclo();
    confere("t3_segura", 8'(db_estado), 8'd3);
    confere("t3_mult", 8'(db_multiplo), 8'd1);
    confere("t3_botao_antigo", 8'(botao_reg), 8'h2);
    confere("t3_jogada", 8'(jogada), 8'd0);
    soltar("t3", 1'b1);

    // 4: long hold with release bounce
    esperados.push_back(4'b1000);
    botoes = 4'b1000;
    repeat (7) ciclo();
    confere("t4_pulso", 8'(jogada), 8'd1);
    repeat (13) ciclo();
    confere("t4_segura", 8'(db_estado), 8'd3);
    botoes = 4'b0000;
    repeat (3) ciclo();
    confere("t4_filtra_solta", 8'(db_estado), 8'd4);
    botoes = 4'b1000;
    repeat (3) ciclo();
    confere("t4_volta_segura", 8'(db_estado), 8'd3);
    soltar("t4", 1'b0);
    confere("t4_botao", 8'(botao_reg), 8'h8);

    // 5: press while disabled, then enable during the hold
    habilita = 1'b0;
    botoes   = 4'b0001;
    repeat (7) ciclo();
    confere("t5_segura", 8'(db_estado), 8'd3);
    confere("t5_botao_antigo", 8'(botao_reg), 8'h8);
    confere("t5_mult", 8'(db_multiplo), 8'd0);
    habilita = 1'b1;
    repeat (5) ciclo();
    confere("t5_continua_segura", 8'(db_estado), 8'd3);
    soltar("t5", 1'b0);
    esperados.push_back(4'b0001);
    botoes = 4'b0001;
    repeat (7) ciclo();
    confere("t5_repress_pulso", 8'(jogada), 8'd1);
    confere("t5_repress_botao", 8'(botao_reg), 8'h1);
    ciclo();
    soltar("t5b", 1'b0);

    // 6: async reset in the middle of the press filter
    botoes = 4'b0100;
    repeat (4) ciclo();
    confere("t6_filtra", 8'(db_estado), 8'd1);
    reset = 1'b0;
    #1;
    confere("t6_rst_estado", 8'(db_estado), 8'd0);
    confere("t6_rst_botao", 8'(botao_reg), 8'd0);
    confere("t6_rst_jogada", 8'(jogada), 8'd0);
    repeat (3) ciclo();
    reset = 1'b1;
    esperados.push_back(4'b0100);
    repeat (6) ciclo();
    confere("t6_pre_pulso", 8'(jogada), 8'd0);
    ciclo();
    confere("t6_jogada", 8'(jogada), 8'd1);
    confere("t6_botao", 8'(botao_reg), 8'h4);
    ciclo();
    soltar("t6", 1'b0);

    repeat (3) ciclo();
    confere("fila_vazia", 8'(esperados.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
